// File: rtl/rn_axis_pkt_player.sv
`default_nettype none
// ============================================================================
// rn_axis_pkt_player : replays a preloaded beat image on an AXI4-Stream master
// Rev 1.0
// ============================================================================
module rn_axis_pkt_player #(
    parameter int DATA_WIDTH      = 512,
    parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int USER_SIZE_WIDTH = 16,
    parameter int DEPTH           = 1024,
    parameter int ADDR_WIDTH      = $clog2(DEPTH),
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_tdata,
    input  logic [KEEP_WIDTH-1:0]      wr_tkeep,
    input  logic                       wr_tlast,
    input  logic [USER_SIZE_WIDTH-1:0] wr_pkt_len,
    input  logic                       wr_skip,
    input  logic [ADDR_WIDTH:0]        cfg_num_beats,
    input  logic [CNT_WIDTH-1:0]       cfg_num_pkts,
    input  logic                       cfg_loop,
    input  logic [CNT_WIDTH-1:0]       cfg_start_delay,
    input  logic [CNT_WIDTH-1:0]       cfg_ipg,
    input  logic                       start,
    input  logic                       abort,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tlast,
    output logic [USER_SIZE_WIDTH-1:0] m_axis_tuser_size,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [CNT_WIDTH-1:0]       pkt_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DELAY = 3'd1;
    localparam logic [2:0] S_SEND  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   BEATS_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0]      mem_data [DEPTH];
    logic [KEEP_WIDTH-1:0]      mem_keep [DEPTH];
    logic [USER_SIZE_WIDTH-1:0] mem_len  [DEPTH];
    logic                       mem_last [DEPTH];
    logic                       mem_skip [DEPTH];

    logic [2:0]                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]       delay_cnt_q, delay_cnt_d;
    logic [CNT_WIDTH-1:0]       gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]       issued_q, issued_d;
    logic [CNT_WIDTH-1:0]       pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0]      tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]      tkeep_q, tkeep_d;
    logic                       tlast_q, tlast_d;
    logic [USER_SIZE_WIDTH-1:0] tuser_q, tuser_d;
    logic                       tvalid_q, tvalid_d;
    logic                       done_q, done_d;
    logic                       aborted_q, aborted_d;

    logic       w_slot_free, w_hs, w_delay_done, w_gap_done, w_fetch;
    logic       w_last_entry, w_final_pkt, w_beat_last, w_to_drain, w_start_ok;
    logic [2:0] w_fetch_state;

    always_ff @(posedge axis_clk) begin
        if (wr_en && state_q == S_IDLE) begin
            mem_data[wr_addr] <= wr_tdata;
            mem_keep[wr_addr] <= wr_tkeep;
            mem_len[wr_addr]  <= wr_pkt_len;
            mem_last[wr_addr] <= wr_tlast;
            mem_skip[wr_addr] <= wr_skip;
        end
    end

    assign w_slot_free  = !tvalid_q || m_axis_tready;
    assign w_hs         = tvalid_q && m_axis_tready;
    assign w_start_ok   = start && (cfg_num_beats != '0);
    assign w_delay_done = (delay_cnt_q == cfg_start_delay);
    assign w_gap_done   = !tvalid_q && ((gap_cnt_q + CNT_ONE) == cfg_ipg);
    assign w_last_entry = (({1'b0, rd_ptr_q} + BEATS_ONE) == cfg_num_beats);
    assign w_final_pkt  = (cfg_num_pkts != '0) && ((issued_q + CNT_ONE) == cfg_num_pkts);
    assign w_beat_last  = !mem_skip[rd_ptr_q] && mem_last[rd_ptr_q];
    assign w_to_drain   = (!cfg_loop && w_last_entry) || (w_beat_last && w_final_pkt);

    // The last cycle of DELAY and GAP already fetches, so the first beat of a
    // burst appears without an extra bubble.
    assign w_fetch = ((state_q == S_SEND)  && w_slot_free)  ||
                     ((state_q == S_DELAY) && w_delay_done) ||
                     ((state_q == S_GAP)   && w_gap_done);

    assign w_fetch_state = w_to_drain                          ? S_DRAIN :
                           (w_beat_last && (cfg_ipg != '0))    ? S_GAP   : S_SEND;

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (w_start_ok) state_d = S_DELAY;
                S_DELAY,
                S_SEND,
                S_GAP:   if (w_fetch) state_d = w_fetch_state;
                S_DRAIN: if (w_slot_free) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        delay_cnt_d = delay_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        issued_d    = issued_q;
        pkt_cnt_d   = pkt_cnt_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        done_d      = done_q;
        aborted_d   = aborted_q;

        if (w_hs && tlast_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_ONE;
        end

        if (state_q == S_IDLE) begin
            if (w_start_ok) begin
                done_d      = 1'b0;
                aborted_d   = 1'b0;
                pkt_cnt_d   = '0;
                rd_ptr_d    = '0;
                issued_d    = '0;
                delay_cnt_d = '0;
            end
        end else if (abort) begin
            tvalid_d  = 1'b0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                S_DELAY: begin
                    if (!w_delay_done) delay_cnt_d = delay_cnt_q + CNT_ONE;
                end
                S_GAP: begin
                    if (w_hs) begin
                        tvalid_d  = 1'b0;
                        gap_cnt_d = '0;
                    end else if (!tvalid_q && !w_gap_done) begin
                        gap_cnt_d = gap_cnt_q + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (w_slot_free) begin
                        tvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end
                end
                default: ;
            endcase

            if (w_fetch) begin
                rd_ptr_d = w_last_entry ? '0 : rd_ptr_q + ADDR_ONE;
                if (mem_skip[rd_ptr_q]) begin
                    tvalid_d = 1'b0;
                end else begin
                    tdata_d  = mem_data[rd_ptr_q];
                    tkeep_d  = mem_keep[rd_ptr_q];
                    tlast_d  = mem_last[rd_ptr_q];
                    tuser_d  = mem_len[rd_ptr_q];
                    tvalid_d = 1'b1;
                    if (mem_last[rd_ptr_q]) issued_d = issued_q + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            rd_ptr_q    <= '0;
            delay_cnt_q <= '0;
            gap_cnt_q   <= '0;
            issued_q    <= '0;
            pkt_cnt_q   <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tuser_q     <= '0;
            tvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            delay_cnt_q <= delay_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            issued_q    <= issued_d;
            pkt_cnt_q   <= pkt_cnt_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign m_axis_tdata      = tdata_q;
    assign m_axis_tkeep      = tkeep_q;
    assign m_axis_tlast      = tlast_q;
    assign m_axis_tuser_size = tuser_q;
    assign m_axis_tvalid     = tvalid_q;
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign aborted           = aborted_q;
    assign pkt_cnt           = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rn_axis_pkt_player.sv
`default_nettype none
// ============================================================================
// tb_rn_axis_pkt_player : table-driven and randomized bench for the replay engine
// Rev 1.0
// ============================================================================
module tb_rn_axis_pkt_player;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int UW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 32;

    logic          axis_clk = 1'b0;
    logic          axis_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_tdata = '0;
    logic [KW-1:0] wr_tkeep = '0;
    logic          wr_tlast = 1'b0;
    logic [UW-1:0] wr_pkt_len = '0;
    logic          wr_skip = 1'b0;
    logic [AW:0]   cfg_num_beats = '0;
    logic [CW-1:0] cfg_num_pkts = '0;
    logic          cfg_loop = 1'b0;
    logic [CW-1:0] cfg_start_delay = '0;
    logic [CW-1:0] cfg_ipg = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser_size;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          busy, done, aborted;
    logic [CW-1:0] pkt_cnt;

    rn_axis_pkt_player #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_SIZE_WIDTH(UW),
        .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
    ) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tdata(wr_tdata), .wr_tkeep(wr_tkeep),
        .wr_tlast(wr_tlast), .wr_pkt_len(wr_pkt_len), .wr_skip(wr_skip),
        .cfg_num_beats(cfg_num_beats), .cfg_num_pkts(cfg_num_pkts), .cfg_loop(cfg_loop),
        .cfg_start_delay(cfg_start_delay), .cfg_ipg(cfg_ipg),
        .start(start), .abort(abort),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser_size(m_axis_tuser_size), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .done(done), .aborted(aborted), .pkt_cnt(pkt_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [UW-1:0] len;
    } beat_t;

    // img: image id (0 = three packets, 1 = skip inside a packet, 2 = one 2-beat packet)
    typedef struct {
        int img; int nb; int np; int loop; int dly; int ipg; int rnd;
        int exp_beats; int exp_pkts; int exp_first; int exp_idle;
    } case_t;

    logic [DW-1:0] img_data [DEPTH];
    logic [KW-1:0] img_keep [DEPTH];
    logic          img_last [DEPTH];
    logic [UW-1:0] img_len  [DEPTH];
    logic          img_skip [DEPTH];

    beat_t exp_q[$];
    case_t cases[10];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    task automatic write_entry(input int a, input logic [DW-1:0] d, input logic [KW-1:0] k,
                               input logic l, input logic [UW-1:0] len, input logic s);
        @(negedge axis_clk);
        wr_en      = 1'b1;
        wr_addr    = AW'(a);
        wr_tdata   = d;
        wr_tkeep   = k;
        wr_tlast   = l;
        wr_pkt_len = len;
        wr_skip    = s;
        img_data[a] = d; img_keep[a] = k; img_last[a] = l; img_len[a] = len; img_skip[a] = s;
        @(posedge axis_clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic load_image(input int id);
        case (id)
            0: begin
                write_entry(0, rnd_data(), 8'hFF, 1'b0, 16'd100, 1'b0);
                write_entry(1, rnd_data(), 8'h0F, 1'b1, 16'd100, 1'b0);
                write_entry(2, rnd_data(), 8'hFF, 1'b1, 16'd64,  1'b0);
                write_entry(3, rnd_data(), 8'hFF, 1'b0, 16'd180, 1'b0);
                write_entry(4, rnd_data(), 8'hFF, 1'b0, 16'd180, 1'b0);
                write_entry(5, rnd_data(), 8'h0F, 1'b1, 16'd180, 1'b0);
            end
            1: begin
                write_entry(0, rnd_data(), 8'hFF, 1'b0, 16'd150, 1'b0);
                write_entry(1, rnd_data(), 8'hFF, 1'b0, 16'd150, 1'b1);
                write_entry(2, rnd_data(), 8'h3F, 1'b1, 16'd150, 1'b0);
            end
            default: begin
                write_entry(0, rnd_data(), 8'hFF, 1'b0, 16'd120, 1'b0);
                write_entry(1, rnd_data(), 8'hFF, 1'b1, 16'd120, 1'b0);
            end
        endcase
    endtask

    // Reference: walk the image in order, emit every non-skip entry, stop once
    // np packets have been emitted or (without loop) the image is exhausted.
    task automatic build_expected(input int nb, input int np, input int loop);
        int ptr = 0;
        int issued = 0;
        bit at_end;
        beat_t b;
        exp_q.delete();
        for (int guard = 0; guard < 1000; guard++) begin
            at_end = (ptr == nb - 1);
            if (!img_skip[ptr]) begin
                b.data = img_data[ptr]; b.keep = img_keep[ptr];
                b.last = img_last[ptr]; b.len  = img_len[ptr];
                exp_q.push_back(b);
                if (img_last[ptr]) begin
                    issued++;
                    if (np != 0 && issued == np) break;
                end
            end
            if (at_end && loop == 0) break;
            ptr = at_end ? 0 : ptr + 1;
        end
    endtask

    task automatic run_case(input case_t c);
        int    model_beats, model_pkts, first_v, last_hs, idle, nbeats, end_cyc;
        bit    prev_stall, ended;
        beat_t prev, cur, e;
        build_expected(c.nb, c.np, c.loop);
        model_beats = exp_q.size();
        model_pkts  = 0;
        foreach (exp_q[k]) if (exp_q[k].last) model_pkts++;
        if (c.exp_beats >= 0) begin
            model_beats = c.exp_beats;
            model_pkts  = c.exp_pkts;
        end
        cfg_num_beats   = (AW+1)'(c.nb);
        cfg_num_pkts    = CW'(c.np);
        cfg_loop        = (c.loop != 0);
        cfg_start_delay = CW'(c.dly);
        cfg_ipg         = CW'(c.ipg);
        first_v = -1; last_hs = -1; idle = 0; nbeats = 0; end_cyc = 0;
        prev_stall = 1'b0; ended = 1'b0;
        prev = '{default: '0};
        @(negedge axis_clk);
        start = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge axis_clk);
            if (i == 1) begin
                start = 1'b0;
                check("start_busy",    64'(busy),    64'd1);
                check("start_done",    64'(done),    64'd0);
                check("start_aborted", 64'(aborted), 64'd0);
                check("start_pkt_cnt", 64'(pkt_cnt), 64'd0);
            end
            if (!busy) begin
                ended   = 1'b1;
                end_cyc = i;
                break;
            end
            m_axis_tready = (c.rnd != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            cur.data = m_axis_tdata; cur.keep = m_axis_tkeep;
            cur.last = m_axis_tlast; cur.len  = m_axis_tuser_size;
            if (prev_stall) begin
                check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                check("stall_tdata",  cur.data,           prev.data);
                check("stall_tkeep",  64'(cur.keep),      64'(prev.keep));
                check("stall_tlast",  64'(cur.last),      64'(prev.last));
                check("stall_tuser",  64'(cur.len),       64'(prev.len));
            end
            if (m_axis_tvalid && first_v < 0) first_v = i;
            if (!m_axis_tvalid && first_v >= 0) idle++;
            if (m_axis_tvalid && m_axis_tready) begin
                nbeats++;
                last_hs = i;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: got beat tdata %0h, expected no more beats", cur.data);
                end else begin
                    e = exp_q.pop_front();
                    if (cur.data !== e.data || cur.keep !== e.keep ||
                        cur.last !== e.last || cur.len !== e.len) begin
                        n_fail++;
                        $display("FAIL beat %0d: got d=%0h k=%0h l=%0b u=%0d, expected d=%0h k=%0h l=%0b u=%0d",
                                 nbeats, cur.data, cur.keep, cur.last, cur.len,
                                 e.data, e.keep, e.last, e.len);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev = cur;
        end
        check("timeout",      64'(ended),        64'd1);
        check("beat_count",   64'(nbeats),       64'(model_beats));
        check("beats_left",   64'(exp_q.size()), 64'd0);
        check("pkt_cnt",      64'(pkt_cnt),      64'(model_pkts));
        check("done",         64'(done),         64'd1);
        check("aborted_end",  64'(aborted),      64'd0);
        if (c.exp_first >= 0) begin
            check("first_valid", 64'(first_v), 64'(c.exp_first));
            check("done_latency", 64'(end_cyc), 64'(last_hs + 1));
        end
        if (c.exp_idle >= 0) check("idle_cycles", 64'(idle), 64'(c.exp_idle));
        m_axis_tready = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        case_t rc;
        bit    found;
        int    nb, lp, np;
        bit    sk, la;

        cases[0] = '{0, 6, 3, 0, 0,  0, 0,  6, 3,  2, 0};
        cases[1] = '{0, 6, 3, 0, 0,  0, 1,  6, 3, -1, -1};
        cases[2] = '{0, 6, 3, 0, 10, 4, 0,  6, 3, 12, 8};
        cases[3] = '{0, 6, 0, 0, 0,  0, 0,  6, 3,  2, 0};
        cases[4] = '{0, 6, 2, 0, 0,  0, 0,  3, 2,  2, 0};
        cases[5] = '{0, 4, 0, 0, 0,  0, 0,  4, 2,  2, 0};
        cases[6] = '{0, 6, 4, 1, 0,  1, 0,  8, 4,  2, 3};
        cases[7] = '{1, 3, 1, 0, 0,  0, 0,  2, 1,  2, 1};
        cases[8] = '{2, 2, 5, 1, 0,  0, 0, 10, 5,  2, 0};
        cases[9] = '{2, 2, 5, 1, 0,  0, 1, 10, 5, -1, -1};

        repeat (3) @(negedge axis_clk);
        axis_rst = 1'b0;
        @(negedge axis_clk);
        check("rst_tvalid",  64'(m_axis_tvalid), 64'd0);
        check("rst_busy",    64'(busy),          64'd0);
        check("rst_done",    64'(done),          64'd0);
        check("rst_aborted", 64'(aborted),       64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt),       64'd0);
        check("rst_tdata",   m_axis_tdata,       64'd0);
        check("rst_tlast",   64'(m_axis_tlast),  64'd0);

        cfg_num_beats = '0;
        start = 1'b1;
        @(negedge axis_clk);
        start = 1'b0;
        @(negedge axis_clk);
        check("zero_beats_start", 64'(busy), 64'd0);

        foreach (cases[k]) begin
            load_image(cases[k].img);
            run_case(cases[k]);
        end

        // Abort mid-packet, with a write attempted while busy.
        load_image(0);
        cfg_num_beats = 5'd6; cfg_num_pkts = 32'd3; cfg_loop = 1'b0;
        cfg_start_delay = 32'd3; cfg_ipg = 32'd0;
        m_axis_tready = 1'b1;
        @(negedge axis_clk);
        start = 1'b1;
        @(negedge axis_clk);
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd1);
        wr_en = 1'b1; wr_addr = '0; wr_tdata = ~img_data[0]; wr_tkeep = 8'h01;
        wr_tlast = 1'b1; wr_pkt_len = 16'd1; wr_skip = 1'b0;
        @(negedge axis_clk);
        wr_en = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (m_axis_tvalid) begin
                found = 1'b1;
                break;
            end
            @(negedge axis_clk);
        end
        check("abort_first_valid", 64'(found), 64'd1);
        check("busy_write_dropped", m_axis_tdata, img_data[0]);
        @(negedge axis_clk);
        check("abort_mid_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("abort_mid_tdata",  m_axis_tdata,        img_data[1]);
        m_axis_tready = 1'b0;
        abort = 1'b1;
        @(negedge axis_clk);
        abort = 1'b0;
        check("abort_tvalid",  64'(m_axis_tvalid), 64'd0);
        check("abort_flag",    64'(aborted),       64'd1);
        check("abort_idle",    64'(busy),          64'd0);
        check("abort_done",    64'(done),          64'd0);
        check("abort_pkt_cnt", 64'(pkt_cnt),       64'd0);
        run_case(cases[0]);

        // Randomized images and configurations against the reference walk.
        for (int r = 0; r < 20; r++) begin
            nb = int'($urandom_range(1, DEPTH));
            lp = int'($urandom_range(0, 1));
            np = int'($urandom_range((lp != 0) ? 1 : 0, 4));
            for (int a = 0; a < nb; a++) begin
                sk = ($urandom_range(0, 7) == 0);
                la = ($urandom_range(0, 2) == 0);
                if (a == nb - 1 && lp != 0) begin
                    sk = 1'b0;
                    la = 1'b1;
                end
                write_entry(a, rnd_data(), KW'($urandom), la, UW'($urandom), sk);
            end
            rc = '{0, nb, np, lp, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1,
                   -1, -1, -1, -1};
            run_case(rc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
